grf_wport_arbiter: RTL and testbench

- Shares the single GRF write port between two requesters: the pipeline WB stage and the long-latency multiply/divide result path.
- Keeps a 32-entry scoreboard of destination registers with an md result still outstanding, and drives read-operand stall flags to the ID stage.
- Guarantees md forward progress with a starvation counter; when it expires, the block requests a one-cycle pipeline freeze.
- Sits between the WB/md stages and the GRF write inputs (RegWrite/RegAddr/RegData).

---
 rtl/grf_wport_arbiter.sv | 69 ++++++
 tb/tb_grf_wport_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/grf_wport_arbiter.sv
// grf_wport_arbiter: shares the GRF write port between WB and the md result path,
// tracks md-pending destinations and forces a one-cycle freeze when md starves.
module grf_wport_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_addr,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        stall_rs,
  output logic        stall_rt,
  output logic        wb_hold,
  output logic        RegWrite,
  output logic [4:0]  RegAddr,
  output logic [31:0] RegData
);
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);
  state_t           state, stateNext;
  logic [CNT_W-1:0] waitCnt, waitCntNext;
  logic [31:0]      pending, pendingNext;
  logic             inHold, wbReq, wbGrant, mdGrant, blocked;
  always_comb begin
    inHold  = state == HOLD;
    wbReq   = wb_we && wb_addr != 5'd0;
    wbGrant = reset && !inHold && wbReq;
    mdGrant = reset && md_valid && (inHold || !wbReq);
    blocked = md_valid && !mdGrant && !inHold;
  end
  // Outputs are gated by reset so they drop as soon as reset asserts.
  always_comb begin
    md_ready = mdGrant;
    RegWrite = wbGrant || (mdGrant && md_addr != 5'd0);
    RegAddr  = wbGrant ? wb_addr : mdGrant ? md_addr : 5'd0;
    RegData  = wbGrant ? wb_data : mdGrant ? md_data : 32'd0;
    wb_hold  = inHold;
    stall_rs = reset && rs_addr != 5'd0 && pending[rs_addr] && !(mdGrant && md_addr == rs_addr);
    stall_rt = reset && rt_addr != 5'd0 && pending[rt_addr] && !(mdGrant && md_addr == rt_addr);
  end
  always_comb begin
    stateNext   = (!inHold && blocked && waitCnt == LAST) ? HOLD : IDLE;
    waitCntNext = (blocked && waitCnt != LAST) ? waitCnt + 1'b1 : '0;
    pendingNext = pending;
    if (mdGrant && md_addr != 5'd0) pendingNext[md_addr] = 1'b0;
    // Applied after the clear so a same-cycle reissue keeps the register pending.
    if (md_issue && md_issue_addr != 5'd0) pendingNext[md_issue_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      waitCnt <= '0;
      pending <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      pending <= pendingNext;
    end
  end
endmodule

// File: tb/tb_grf_wport_arbiter.sv
// tb_grf_wport_arbiter: scenario tasks driving the arbiter against a queue of expected port values.
module tb_grf_wport_arbiter;
  localparam int MW = 4;
  logic clk = 0, reset = 0;
  logic wb_we, md_valid, md_issue, md_ready, stall_rs, stall_rt, wb_hold, RegWrite;
  logic [4:0] wb_addr, md_addr, md_issue_addr, rs_addr, rt_addr, RegAddr;
  logic [31:0] wb_data, md_data, RegData;
  typedef struct {string name; logic [41:0] v;} exp_t;
  exp_t q[$];
  exp_t e;
  int passed = 0, total = 0;

  grf_wport_arbiter #(.MAX_WAIT(MW), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
    .md_issue(md_issue), .md_issue_addr(md_issue_addr), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .stall_rs(stall_rs), .stall_rt(stall_rt), .wb_hold(wb_hold),
    .RegWrite(RegWrite), .RegAddr(RegAddr), .RegData(RegData));

  always #5 clk = ~clk;

  function automatic logic [41:0] mk(logic we, logic [4:0] a, logic [31:0] d, logic r, logic s, logic t, logic h);
    return {we, a, d, r, s, t, h};
  endfunction

  function automatic logic [41:0] obs();
    return {RegWrite, RegAddr, RegData, md_ready, stall_rs, stall_rt, wb_hold};
  endfunction

  task automatic setIn(logic we, logic [4:0] wa, logic [31:0] wd, logic mv, logic [4:0] ma, logic [31:0] md,
                       logic iss, logic [4:0] ia, logic [4:0] rs, logic [4:0] rt);
    @(negedge clk);
    wb_we = we; wb_addr = wa; wb_data = wd;
    md_valid = mv; md_addr = ma; md_data = md;
    md_issue = iss; md_issue_addr = ia; rs_addr = rs; rt_addr = rt;
  endtask

  task automatic test_reset();
    setIn(1, 5, 32'h1, 1, 6, 32'h2, 1, 6, 6, 6);
    q.push_back('{"reset_outputs", mk(0, 0, 0, 0, 0, 0, 0)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    @(negedge clk) reset = 1;
  endtask

  task automatic test_wb_only();
    setIn(1, 5, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
    q.push_back('{"wb_write", mk(1, 5, 32'h12345678, 0, 0, 0, 0)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    setIn(1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
    q.push_back('{"wb_zero_reg", mk(0, 0, 0, 0, 0, 0, 0)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
  endtask

  task automatic test_idle_slot_md();
    setIn(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    q.push_back('{"issue_no_stall_yet", mk(0, 0, 0, 0, 0, 0, 0)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
    q.push_back('{"pending_stall", mk(0, 0, 0, 0, 1, 1, 0)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    setIn(0, 0, 0, 1, 9, 32'hCAFEBABE, 0, 0, 9, 9);
    q.push_back('{"md_accept_bypass", mk(1, 9, 32'hCAFEBABE, 1, 0, 0, 0)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
    q.push_back('{"pending_cleared", mk(0, 0, 0, 0, 0, 0, 0)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
  endtask

  task automatic test_starvation();
    setIn(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    q.push_back('{"issue7", mk(0, 0, 0, 0, 0, 0, 0)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    for (int i = 0; i < MW; i++) begin
      setIn(1, 5, 32'h11111111, 1, 7, 32'hDEADBEEF, 0, 0, 7, 0);
      q.push_back('{$sformatf("starve_blocked%0d", i), mk(1, 5, 32'h11111111, 0, 1, 0, 0)});
      #2 e = q.pop_front(); total++;
      if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    end
    setIn(1, 5, 32'h11111111, 1, 7, 32'hDEADBEEF, 0, 0, 7, 0);
    q.push_back('{"starve_hold", mk(1, 7, 32'hDEADBEEF, 1, 0, 0, 1)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    setIn(1, 5, 32'h11111111, 0, 0, 0, 0, 0, 7, 0);
    q.push_back('{"after_hold", mk(1, 5, 32'h11111111, 0, 0, 0, 0)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
  endtask

  task automatic test_set_clear();
    setIn(0, 0, 0, 0, 0, 0, 1, 3, 0, 3);
    q.push_back('{"issue3", mk(0, 0, 0, 0, 0, 0, 0)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    setIn(0, 0, 0, 1, 3, 32'h33, 1, 3, 0, 3);
    q.push_back('{"accept_and_reissue3", mk(1, 3, 32'h33, 1, 0, 0, 0)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    setIn(0, 0, 0, 1, 0, 32'h77, 0, 0, 0, 3);
    q.push_back('{"set_wins_md_to_zero", mk(0, 0, 32'h77, 1, 0, 1, 0)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
  endtask

  task automatic test_reset_mid_hold();
    setIn(0, 0, 0, 0, 0, 0, 1, 9, 3, 9);
    q.push_back('{"issue9", mk(0, 0, 0, 0, 1, 0, 0)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    for (int i = 0; i < MW; i++) begin
      setIn(1, 5, 32'hAAAA, 1, 12, 32'hBBBB, 0, 0, 3, 9);
      q.push_back('{$sformatf("rst_blocked%0d", i), mk(1, 5, 32'hAAAA, 0, 1, 1, 0)});
      #2 e = q.pop_front(); total++;
      if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    end
    setIn(1, 5, 32'hAAAA, 1, 12, 32'hBBBB, 0, 0, 3, 9);
    q.push_back('{"rst_in_hold", mk(1, 12, 32'hBBBB, 1, 1, 1, 1)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    #1 reset = 0;
    q.push_back('{"async_reset_drop", mk(0, 0, 0, 0, 0, 0, 0)});
    #1 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 3, 9);
    reset = 1;
    q.push_back('{"pending_reset", mk(0, 0, 0, 0, 0, 0, 0)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
  endtask

  task automatic test_counter_reset();
    for (int i = 0; i < 2; i++) begin
      setIn(1, 4, 32'h44, 1, 8, 32'h88, 0, 0, 0, 0);
      #2;
    end
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 0;
    @(negedge clk) reset = 1;
    for (int i = 0; i < MW; i++) begin
      setIn(1, 4, 32'h44, 1, 8, 32'h88, 0, 0, 0, 0);
      q.push_back('{$sformatf("cnt_after_reset%0d", i), mk(1, 4, 32'h44, 0, 0, 0, 0)});
      #2 e = q.pop_front(); total++;
      if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    end
    setIn(1, 4, 32'h44, 1, 8, 32'h88, 0, 0, 0, 0);
    q.push_back('{"cnt_hold", mk(1, 8, 32'h88, 1, 0, 0, 1)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    q.push_back('{"cnt_idle", mk(0, 0, 0, 0, 0, 0, 0)});
    #2 e = q.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_idle_slot_md();
    test_starvation();
    test_set_clear();
    test_reset_mid_hold();
    test_counter_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
